// File: rtl/adder_pipe.sv
// Chunked ripple-carry adder pipeline: one CW-bit slice per stage, with valid/ready flow control.
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The whole pipeline moves together whenever the output slot is empty or being drained.
  logic advance;

  // Per-stage registers: operands still to be consumed, partial sum, chunk carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];

  // Stage inputs: stage 0 sees the ports, stage k sees stage k-1's registers.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  assign advance  = !v_q[LAST] || out_ready;
  assign in_ready = advance;

  always_comb begin
    a_in[0] = a;
    b_in[0] = b;
    s_in[0] = '0;
    c_in[0] = cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic [CW:0] part;
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
           + {{CW{1'b0}}, c_in[k]};
      s_d[k]             = s_in[k];
      s_d[k][k*CW +: CW] = part[CW-1:0];
      c_d[k]             = part[CW];
      a_d[k]             = a_in[k];
      b_d[k]             = b_in[k];
      v_d[k]             = v_in[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];

`ifdef ADDER_PIPE_OVF_EN
  // Overflow is formed in the last stage so it is registered alongside sum.
  logic ovf_d, ovf_q;

  assign ovf_d = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
                 (s_d[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vector table, backpressure/reset sequences,
// random streams on the default build and on an 8-bit single-stage instance.
module tb_adder_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (32 bits, 4 stages) ----------------
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
`ifdef ADDER_PIPE_OVF_EN
  logic        ovf;
`endif

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  // ---------------- small DUT (8 bits, 1 stage) ----------------
  logic       s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout;
  logic [7:0] s_a, s_b, s_sum;
`ifdef ADDER_PIPE_OVF_EN
  logic       s_ovf;
`endif

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        vecs [8];
  logic [33:0] exp_q [$];   // {ovf, cout, sum}
  logic [8:0]  exp8_q [$];  // {cout, sum}
  int          n_total, n_bad, pops;
  logic        acc_last, stall_prev;
  logic [32:0] held_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] r;
    logic        o;
    r = {1'b0, x} + {1'b0, y} + {32'd0, c};
    o = (x[31] == y[31]) && (r[31] != x[31]);
    return {o, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; drives one cycle, scores, returns at the next negedge.
  task automatic tick_main(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                           input logic ic, input logic ordy);
    logic [33:0] e;
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", {cout, sum}, held_prev);
    end
    check("in_ready_rule", in_ready, !out_valid || ordy);
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e[31:0]);
        check("cout", cout, e[32]);
`ifdef ADDER_PIPE_OVF_EN
        check("ovf", ovf, e[33]);
`endif
        pops++;
      end
    end
    acc_last = iv && in_ready;
    if (acc_last) exp_q.push_back(model(ia, ib, ic));
    stall_prev = out_valid && !ordy;
    held_prev  = {cout, sum};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_small(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                            input logic ic, input logic ordy);
    logic [8:0] e;
    s_in_valid = iv; s_a = ia; s_b = ib; s_cin = ic; s_out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("s_hold_valid", s_out_valid, 1'b1);
      check("s_hold_result", {s_cout, s_sum}, held_prev[8:0]);
    end
    check("s_in_ready_rule", s_in_ready, !s_out_valid || ordy);
    if (s_out_valid && ordy) begin
      if (exp8_q.size() == 0) begin
        check("s_spurious_result", 1'b1, 1'b0);
      end else begin
        e = exp8_q.pop_front();
        check("s_result", {s_cout, s_sum}, e);
      end
    end
    acc_last = iv && s_in_ready;
    if (acc_last) exp8_q.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ic});
    stall_prev = s_out_valid && !ordy;
    held_prev  = {24'd0, s_cout, s_sum};
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single item through an empty pipe with out_ready=1: latency and one-cycle pulse.
  task automatic run_vec(input vec_t v);
    int lat;
    in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; out_ready = 1'b1;
    #1;
    check("vec_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("vec_latency", lat, 4);
    check("vec_sum", sum, v.sum);
    check("vec_cout", cout, v.cout);
`ifdef ADDER_PIPE_OVF_EN
    check("vec_ovf", ovf, v.ovf);
`endif
    @(posedge clk);
    @(negedge clk);
    check("vec_pulse_end", out_valid, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int idx, acc, cyc;
    vec_t v57;

    n_total = 0; n_bad = 0; pops = 0;
    acc_last = 1'b0; stall_prev = 1'b0; held_prev = '0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_out_ready = 1'b0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

    // Reset state.
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", cout, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_s_out_valid", s_out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Directed vector table.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: six back-to-back items, out_ready low for cycles 5..9.
    idx = 0; pops = 0;
    for (int c = 0; c < 40 && (idx < 6 || exp_q.size() > 0); c++) begin
      tick_main(idx < 6, 32'(idx + 1), 32'(10 * (idx + 1)), 1'((idx + 1) & 1),
                !(c >= 5 && c <= 9));
      if (acc_last) idx++;
    end
    check("bp_accepted", idx, 6);
    check("bp_results", pops, 6);

    // Reset mid-flight: three items in flight, oldest stalled at the output.
    for (int i = 0; i < 3; i++) tick_main(1'b1, 32'(100 + i), 32'(200 + i), 1'b0, 1'b1);
    tick_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mid_rst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 32'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("mid_rst_no_leftover", out_valid, 1'b0);
    v57 = '{32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0};
    run_vec(v57);

    // Random stream on the main DUT.
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 8000) begin
      tick_main(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0);
      if (acc_last) acc++;
      cyc++;
    end
    check("rand_accepted", acc, 1000);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick_main(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rand_drained", exp_q.size(), 0);
    stall_prev = 1'b0;
    in_valid = 1'b0;

    // Small DUT: directed latency-1 carry, then random stream.
    tick_small(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
    check("s_lat1_valid", s_out_valid, 1'b1);
    check("s_lat1_sum", s_sum, 8'h00);
    check("s_lat1_cout", s_cout, 1'b1);
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 8000) begin
      tick_small(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
      if (acc_last) acc++;
      cyc++;
    end
    check("s_rand_accepted", acc, 1000);
    for (int i = 0; i < 20 && exp8_q.size() > 0; i++) tick_small(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("s_rand_drained", exp8_q.size(), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
